// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: decodes loads/stores, drives a req/ack bus master,
// stalls the pipeline for the access, aligns/extends load data and times out hung accesses.
module mem_stage_lsu #(
   parameter int ADDR_W     = 32,
   parameter bit BIG_ENDIAN = 1'b0,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ir,
   input  logic              valid_m,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       rt_data,
   output logic              stall,
   output logic [31:0]       ld_data,
   output logic              ld_valid,
   output logic              adel,
   output logic              ades,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: bus_req rises on entry to BUSY and holds with stable
   // addr/be/wdata/we until the cycle bus_ack is sampled high; read data
   // is taken in that same cycle and bus_req drops on the following edge.

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LW  = 6'h23,
                          OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB  = 6'h28,
                          OP_SH  = 6'h29, OP_SWL = 6'h2A, OP_SW  = 6'h2B,
                          OP_SWR = 6'h2E;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q;
   logic [5:0]  op_q;
   logic [1:0]  a_q;
   logic        err_q;

   logic [5:0]  opc;
   logic [1:0]  a;
   logic        is_load, is_store, memop, misalign, start;
   logic [3:0]  be_le;
   logic [31:0] wdata_le;
   logic [4:0]  swl_mask;
   logic        timeout_hit;
   logic [31:0] rd_le, rd_byte_sh, rd_half_sh, ld_ext;
   logic        q_is_load;

   logic unused_ok;
   assign unused_ok = &{1'b0, ir[25:0]};

   function automatic logic [31:0] swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] swap4(input logic [3:0] b);
      return {b[0], b[1], b[2], b[3]};
   endfunction

   assign opc = ir[31:26];
   assign a   = addr[1:0];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      misalign = 1'b0;
      be_le    = 4'h0;
      wdata_le = 32'h0;
      swl_mask = (5'd2 << a) - 5'd1;
      case (opc)
         OP_LB, OP_LBU: is_load = 1'b1;
         OP_LH, OP_LHU: begin is_load = 1'b1; misalign = a[0]; end
         OP_LW:         begin is_load = 1'b1; misalign = (a != 2'd0); end
         OP_SB: begin
            is_store = 1'b1;
            be_le    = 4'b0001 << a;
            wdata_le = {4{rt_data[7:0]}};
         end
         OP_SH: begin
            is_store = 1'b1;
            misalign = a[0];
            be_le    = 4'b0011 << a;
            wdata_le = {2{rt_data[15:0]}};
         end
         OP_SW: begin
            is_store = 1'b1;
            misalign = (a != 2'd0);
            be_le    = 4'hF;
            wdata_le = rt_data;
         end
         OP_SWL: begin
            is_store = 1'b1;
            be_le    = swl_mask[3:0];
            wdata_le = rt_data >> {(2'd3 - a), 3'b000};
         end
         OP_SWR: begin
            is_store = 1'b1;
            be_le    = 4'hF << a;
            wdata_le = rt_data << {a, 3'b000};
         end
         default: ;
      endcase
   end

   assign memop = valid_m & (is_load | is_store);
   assign adel  = valid_m & is_load & misalign;
   assign ades  = valid_m & is_store & misalign;
   assign start = (state_q == S_IDLE) & memop & ~misalign;

   assign timeout_hit = ~bus_ack & (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BUSY;
         S_BUSY:  if (bus_ack || timeout_hit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Read data is brought into little-endian lane order so one extractor serves both endians.
   assign rd_le      = BIG_ENDIAN ? swap32(bus_rdata) : bus_rdata;
   assign rd_byte_sh = rd_le >> {a_q, 3'b000};
   assign rd_half_sh = rd_le >> {a_q[1], 4'b0000};

   always_comb begin
      q_is_load = 1'b1;
      case (op_q)
         OP_LB:   ld_ext = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
         OP_LBU:  ld_ext = {24'h0, rd_byte_sh[7:0]};
         OP_LH:   ld_ext = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
         OP_LHU:  ld_ext = {16'h0, rd_half_sh[15:0]};
         OP_LW:   ld_ext = rd_le;
         default: begin ld_ext = 32'h0; q_is_load = 1'b0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'h0;
         op_q      <= 6'h0;
         a_q       <= 2'd0;
         err_q     <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= 4'h0;
         bus_wdata <= 32'h0;
         ld_data   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == S_BUSY) ? cnt_q + 8'd1 : 8'h0;
         if (start) begin
            op_q      <= opc;
            a_q       <= a;
            err_q     <= 1'b0;
            bus_we    <= is_store;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= is_load ? 4'hF : (BIG_ENDIAN ? swap4(be_le) : be_le);
            bus_wdata <= BIG_ENDIAN ? swap32(wdata_le) : wdata_le;
         end
         if (state_q == S_BUSY) begin
            if (bus_ack) begin
               ld_data <= ld_ext;
            end else if (timeout_hit) begin
               ld_data <= 32'h0;
               err_q   <= 1'b1;
            end
         end
      end
   end

   assign bus_req   = (state_q == S_BUSY);
   assign stall     = start | (state_q == S_BUSY);
   assign ld_valid  = (state_q == S_DONE) & q_is_load;
   assign bus_err   = (state_q == S_DONE) & err_q;
   assign dbg_state = state_q;

endmodule
